// File: rtl/iic_target_pkg.sv
// Shared types and register map for the I2C target register-file model.
package iic_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } iic_state_t;

    localparam logic [7:0] REG_ID         = 8'h00;
    localparam logic [7:0] REG_INT_ENABLE = 8'h2E;
    localparam logic [7:0] REG_INT_MAP    = 8'h2F;
    localparam logic [7:0] REG_INT_SOURCE = 8'h30;

    // Registers whose bus writes are acknowledged but dropped.
    function automatic logic is_read_only(input logic [7:0] addr);
        return (addr == REG_ID) || (addr == REG_INT_SOURCE);
    endfunction

endpackage

// File: rtl/iic_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus edge and START/STOP detection
// on the synchronised levels. Idle bus level (both high) after reset.
module iic_line_sync (
    input  logic clk,
    input  logic resetn,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Synchroniser chain and one-cycle history for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign sda       = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_d;
    assign scl_fall  = ~scl_sync[1] & scl_d;
    assign start_det = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];

endmodule

// File: rtl/iic_target_regfile.sv
// I2C target with byte register file, auto-incrementing pointer and a
// periodic multi-source interrupt engine mapped onto two IRQ pins.
//
// state        | meaning
// ST_IDLE      | bus free or not addressed
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for matched address
// ST_PTR       | shifting in register pointer
// ST_PTR_ACK   | driving ACK for pointer byte
// ST_WR_DATA   | shifting in write data
// ST_WR_ACK    | driving ACK for write data
// ST_RD_DATA   | driving read data MSB-first
// ST_RD_ACK    | sampling master ACK/NACK
// ST_WAIT_STOP | ignoring bus until STOP/START
module iic_target_regfile
    import iic_target_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR        = 7'h53,
    parameter int         REG_COUNT          = 64,
    parameter logic [7:0] ID_VALUE           = 8'hE5,
    parameter int         IRQ_SOURCES        = 2,
    parameter int         INTERRUPT_INTERVAL = 300000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       IIC_SCL_I,
    input  logic       IIC_SDA_I,
    output logic       IIC_SCL_O,
    output logic       IIC_SDA_O,
    output logic [1:0] IRQ,
    output logic       BUSY
);
    localparam int         AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);
    localparam logic [7:0] PTR_LAST  = 8'(REG_COUNT - 1);

    iic_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] rx;
    logic [6:0] tx;
    logic [7:0] ptr;
    logic       rw;
    logic       ack_on;
    logic       sda_o;
    logic       busy;

    logic [7:0] regs [REG_COUNT];
    logic [7:0] int_enable;
    logic [7:0] int_map;
    logic [7:0] int_source;
    logic [IRQ_SOURCES-1:0] src_fire;
    logic [1:0] irq_c;

    logic sda, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in, rd_data, ptr_next;
    logic byte_done, ptr_valid, wr_fire, int_clr;

    iic_line_sync u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .scl_in    (IIC_SCL_I),
        .sda_in    (IIC_SDA_I),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in   = {rx, sda};
    assign byte_done = scl_rise && (bit_cnt == 3'd7) && !start_det && !stop_det;
    assign ptr_next  = (ptr == PTR_LAST) ? 8'h00 : ptr + 8'd1;
    assign ptr_valid = ({1'b0, ptr} < REG_LIMIT);
    assign wr_fire   = (state == ST_WR_DATA) && byte_done;
    assign int_clr   = (state == ST_RD_DATA) && byte_done && ptr_valid && (ptr == REG_INT_SOURCE);

    // Read data seen by the master for the current pointer.
    always_comb begin
        rd_data = 8'h00;
        if (ptr_valid) begin
            case (ptr)
                REG_ID:         rd_data = ID_VALUE;
                REG_INT_ENABLE: rd_data = int_enable;
                REG_INT_MAP:    rd_data = int_map;
                REG_INT_SOURCE: rd_data = int_source;
                default:        rd_data = regs[ptr[AW-1:0]];
            endcase
        end
    end

    // Protocol FSM: bit counting, pointer, ACK and read-data drive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            rx      <= 7'd0;
            tx      <= 7'd0;
            ptr     <= 8'h00;
            rw      <= 1'b0;
            ack_on  <= 1'b0;
            sda_o   <= 1'b1;
            busy    <= 1'b0;
        end else if (start_det || stop_det) begin
            state   <= start_det ? ST_ADDR : ST_IDLE;
            bit_cnt <= 3'd0;
            ack_on  <= 1'b0;
            sda_o   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        rx      <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_ADDR) begin
                                if (byte_in[7:1] == DEVICE_ADDR) begin
                                    state <= ST_ADDR_ACK;
                                    rw    <= byte_in[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end else if (state == ST_PTR) begin
                                ptr   <= byte_in;
                                state <= ST_PTR_ACK;
                            end else begin
                                ptr   <= ptr_next;
                                state <= ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    // First fall after bit 8 pulls SDA low, the next one ends the ACK.
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_o  <= 1'b0;
                            ack_on <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (state == ST_ADDR_ACK && rw) begin
                                state <= ST_RD_DATA;
                                tx    <= rd_data[6:0];
                                sda_o <= rd_data[7];
                            end else begin
                                sda_o <= 1'b1;
                                state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_o <= tx[6];
                        tx    <= {tx[5:0], 1'b0};
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            sda_o <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= ST_RD_DATA;
                            tx      <= rd_data[6:0];
                            sda_o   <= rd_data[7];
                        end
                    end else if (scl_rise && !ack_on) begin
                        if (!sda) begin
                            ack_on <= 1'b1;
                            ptr    <= ptr_next;
                        end else begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file writes; read-only and out-of-range targets are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 8'h00;
            end
            int_enable <= 8'h00;
            int_map    <= 8'h00;
        end else if (wr_fire && ptr_valid && !is_read_only(ptr)) begin
            if (ptr == REG_INT_ENABLE) begin
                int_enable <= byte_in;
            end else if (ptr == REG_INT_MAP) begin
                int_map <= byte_in;
            end else begin
                regs[ptr[AW-1:0]] <= byte_in;
            end
        end
    end

    for (genvar g = 0; g < IRQ_SOURCES; g++) begin : g_src
        localparam logic [31:0] RELOAD = 32'(INTERRUPT_INTERVAL * (g + 1) - 1);
        logic [31:0] timer;

        // Period timer: held at reload while disabled, fires at zero.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                timer <= RELOAD;
            end else if (!int_enable[g] || timer == 32'd0) begin
                timer <= RELOAD;
            end else begin
                timer <= timer - 32'd1;
            end
        end

        assign src_fire[g] = int_enable[g] && (timer == 32'd0);
    end

    // Sticky interrupt sources; a new event beats a read-clear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            int_source <= 8'h00;
        end else begin
            int_source <= (int_clr ? 8'h00 : int_source) | 8'(src_fire);
        end
    end

    // Route enabled pending sources to the pin chosen in INT_MAP.
    always_comb begin
        irq_c = 2'b00;
        for (int i = 0; i < IRQ_SOURCES; i++) begin
            if (int_source[i] && int_enable[i]) begin
                irq_c[int_map[i]] = 1'b1;
            end
        end
    end

    assign IRQ       = irq_c;
    assign BUSY      = busy;
    assign IIC_SDA_O = sda_o;
    assign IIC_SCL_O = 1'b1;

endmodule

// File: tb/tb_iic_target_regfile.sv
// Directed bench for iic_target_regfile acting as an I2C master.
module tb_iic_target_regfile;

    localparam int N = 3000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       scl_o, sda_o, busy;
    logic [1:0] irq;

    int checks = 0;
    int failures = 0;
    int low_cnt = 0;
    int busy_cnt = 0;

    assign sda_line = sda_m & sda_o;

    iic_target_regfile #(.INTERRUPT_INTERVAL(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .IIC_SCL_I (scl),
        .IIC_SDA_I (sda_line),
        .IIC_SCL_O (scl_o),
        .IIC_SDA_O (sda_o),
        .IRQ       (irq),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!sda_o) low_cnt <= low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        if (scl) begin
            sda_m = 1'b1;
            wclk(10);
        end else begin
            wclk(8);
            sda_m = 1'b1;
            wclk(12);
            scl = 1'b1;
            wclk(20);
        end
        sda_m = 1'b0;
        wclk(20);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(8);
        sda_m = 1'b0;
        wclk(12);
        scl = 1'b1;
        wclk(20);
        sda_m = 1'b1;
        wclk(20);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wclk(8);
            sda_m = b[i];
            wclk(12);
            scl = 1'b1;
            wclk(20);
            scl = 1'b0;
        end
        wclk(8);
        sda_m = 1'b1;
        wclk(12);
        scl = 1'b1;
        wclk(10);
        ack = ~sda_line;
        wclk(10);
        scl = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic mack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wclk(20);
            scl = 1'b1;
            wclk(10);
            b[i] = sda_line;
            wclk(10);
            scl = 1'b0;
        end
        wclk(8);
        sda_m = ~mack;
        wclk(12);
        scl = 1'b1;
        wclk(20);
        scl = 1'b0;
        wclk(8);
        sda_m = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
        i2c_start();
        send_byte(8'hA6, acks[2]);
        send_byte(a, acks[1]);
        send_byte(d, acks[0]);
        i2c_stop();
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d, output logic [2:0] acks);
        i2c_start();
        send_byte(8'hA6, acks[2]);
        send_byte(a, acks[1]);
        i2c_start();
        send_byte(8'hA7, acks[0]);
        recv_byte(d, 1'b0);
        i2c_stop();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wclk(5);
        checks++;
        if ({scl_o, sda_o, busy, irq} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_in scl_o/sda_o/busy/irq got=%b exp=11000", {scl_o, sda_o, busy, irq});
        end
        resetn = 1'b1;
        wclk(10);
        checks++;
        if ({scl_o, sda_o, busy, irq} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_out scl_o/sda_o/busy/irq got=%b exp=11000", {scl_o, sda_o, busy, irq});
        end
    endtask

    task automatic test_write_read();
        logic [2:0] a;
        logic ack;
        logic b_mid;
        logic [7:0] d;
        i2c_start();
        send_byte(8'hA6, a[2]);
        b_mid = busy;
        send_byte(8'h31, a[1]);
        send_byte(8'hAB, a[0]);
        i2c_stop();
        checks++;
        if (a !== 3'b111) begin
            failures++;
            $display("FAIL wr_acks got=%b exp=111", a);
        end
        checks++;
        if (b_mid !== 1'b1) begin
            failures++;
            $display("FAIL busy_matched got=%b exp=1", b_mid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_stop got=%b exp=0", busy);
        end
        rd_reg(8'h31, d, a);
        ack = &a;
        checks++;
        if ({ack, d} !== {1'b1, 8'hAB}) begin
            failures++;
            $display("FAIL rd_31 ack/data got=%b/%h exp=1/ab", ack, d);
        end
    endtask

    task automatic test_addr_mismatch();
        logic [2:0] a;
        int l0, b0;
        logic [7:0] d;
        l0 = low_cnt;
        b0 = busy_cnt;
        i2c_start();
        send_byte(8'h3A, a[2]);
        send_byte(8'h31, a[1]);
        send_byte(8'h55, a[0]);
        i2c_stop();
        checks++;
        if (a !== 3'b000) begin
            failures++;
            $display("FAIL mismatch_acks got=%b exp=000", a);
        end
        checks++;
        if (low_cnt - l0 !== 0) begin
            failures++;
            $display("FAIL mismatch_sda_low cycles got=%0d exp=0", low_cnt - l0);
        end
        checks++;
        if (busy_cnt - b0 !== 0) begin
            failures++;
            $display("FAIL mismatch_busy cycles got=%0d exp=0", busy_cnt - b0);
        end
        rd_reg(8'h31, d, a);
        checks++;
        if (d !== 8'hAB) begin
            failures++;
            $display("FAIL mismatch_unchanged got=%h exp=ab", d);
        end
    endtask

    task automatic test_burst_wrap();
        logic [5:0] a;
        logic [7:0] d [4];
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'hE5, 8'h33};
        i2c_start();
        send_byte(8'hA6, a[5]);
        send_byte(8'd62, a[4]);
        send_byte(8'h11, a[3]);
        send_byte(8'h22, a[2]);
        send_byte(8'h77, a[1]);
        send_byte(8'h33, a[0]);
        i2c_stop();
        checks++;
        if (a !== 6'b111111) begin
            failures++;
            $display("FAIL burst_wr_acks got=%b exp=111111", a);
        end
        i2c_start();
        send_byte(8'hA6, a[2]);
        send_byte(8'd62, a[1]);
        i2c_start();
        send_byte(8'hA7, a[0]);
        for (int i = 0; i < 4; i++) recv_byte(d[i], (i < 3));
        i2c_stop();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d[i] !== exp_d[i]) begin
                failures++;
                $display("FAIL burst_rd[%0d] got=%h exp=%h", i, d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_id_readonly();
        logic [2:0] a;
        logic [7:0] d;
        i2c_start();
        send_byte(8'hA6, a[2]);
        send_byte(8'h00, a[1]);
        send_byte(8'h99, a[0]);
        checks++;
        if (a !== 3'b111) begin
            failures++;
            $display("FAIL id_wr_acks got=%b exp=111", a);
        end
        i2c_start();
        send_byte(8'hA6, a[2]);
        send_byte(8'h00, a[1]);
        i2c_start();
        send_byte(8'hA7, a[0]);
        recv_byte(d, 1'b0);
        i2c_stop();
        checks++;
        if (d !== 8'hE5) begin
            failures++;
            $display("FAIL id_rd got=%h exp=e5", d);
        end
    endtask

    task automatic test_interrupts();
        logic [3:0] a;
        logic [1:0] irq0, irq1;
        logic [7:0] d;
        bit seen0, seen1;
        int t0, t1, cyc;
        i2c_start();
        send_byte(8'hA6, a[3]);
        send_byte(8'h2E, a[2]);
        send_byte(8'h03, a[1]);
        send_byte(8'h02, a[0]);
        i2c_stop();
        checks++;
        if ({a, irq} !== 6'b111100) begin
            failures++;
            $display("FAIL int_setup acks/irq got=%b exp=111100", {a, irq});
        end
        seen0 = 0; seen1 = 0; t0 = 0; t1 = 0; cyc = 0; irq0 = 2'b00; irq1 = 2'b00;
        while (!seen1 && cyc < 3 * N + 2000) begin
            wclk(1);
            cyc++;
            if (!seen0 && irq[0]) begin seen0 = 1; t0 = cyc; irq0 = irq; end
            if (!seen1 && irq[1]) begin seen1 = 1; t1 = cyc; irq1 = irq; end
        end
        checks++;
        if ({seen0, seen1} !== 2'b11) begin
            failures++;
            $display("FAIL int_timeout seen got=%b exp=11", {seen0, seen1});
        end
        checks++;
        if (irq0 !== 2'b01) begin
            failures++;
            $display("FAIL int_first_irq got=%b exp=01", irq0);
        end
        checks++;
        if (t1 - t0 !== N) begin
            failures++;
            $display("FAIL int_spacing cycles got=%0d exp=%0d", t1 - t0, N);
        end
        checks++;
        if (irq1 !== 2'b11) begin
            failures++;
            $display("FAIL int_second_irq got=%b exp=11", irq1);
        end
        i2c_start();
        send_byte(8'hA7, a[0]);
        recv_byte(d, 1'b0);
        i2c_stop();
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL int_source_rd got=%h exp=03", d);
        end
        checks++;
        if (irq !== 2'b00) begin
            failures++;
            $display("FAIL int_cleared irq got=%b exp=00", irq);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] a;
        logic [7:0] d;
        wr_reg(8'h31, 8'hAB, a);
        i2c_start();
        send_byte(8'hA6, a[2]);
        send_byte(8'h31, a[1]);
        i2c_start();
        send_byte(8'hA7, a[0]);
        wclk(20);
        scl = 1'b1;
        wclk(20);
        scl = 1'b0;
        wclk(10);
        checks++;
        if (sda_o !== 1'b0) begin
            failures++;
            $display("FAIL midrd_bit6_drive got=%b exp=0", sda_o);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({sda_o, busy, irq} !== 4'b1000) begin
            failures++;
            $display("FAIL midrd_reset sda_o/busy/irq got=%b exp=1000", {sda_o, busy, irq});
        end
        sda_m = 1'b1;
        scl = 1'b1;
        wclk(5);
        resetn = 1'b1;
        wclk(10);
        rd_reg(8'h31, d, a);
        checks++;
        if ({a, d} !== {3'b111, 8'h00}) begin
            failures++;
            $display("FAIL post_reset_rd acks/data got=%b/%h exp=111/00", a, d);
        end
        wr_reg(8'h31, 8'h5C, a);
        rd_reg(8'h31, d, a);
        checks++;
        if (d !== 8'h5C) begin
            failures++;
            $display("FAIL post_reset_wr_rd got=%h exp=5c", d);
        end
        checks++;
        if (irq !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_irq got=%b exp=00", irq);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_mismatch();
        test_burst_wrap();
        test_id_readonly();
        test_interrupts();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iic_target_regfile.md
# iic_target_regfile

Parametrised I2C target model with a byte-wide register file, auto-incrementing pointer, address matching, proper ACK/NACK handling, repeated-START support and a multi-channel interrupt engine with mapped IRQ pins. It is used in testbenches as the sensor-side counterpart of the I2C master and driver logic. It generalises the single-IRQ accelerometer imitation to any device address, register depth and interrupt-source count.

## Interface
- DEVICE_ADDR, 7'h53, 7-bit target address matched after START
- REG_COUNT, 64, number of 8-bit registers (16..256); pointer wraps at REG_COUNT
- ID_VALUE, 8'hE5, reset and read-only content of register 0x00
- IRQ_SOURCES, 2, number of periodic interrupt sources (1..8)
- INTERRUPT_INTERVAL, 300000, base period in clk cycles; source i fires every INTERRUPT_INTERVAL*(i+1)
- clk  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- IIC_SCL_I  in  1  SCL line level
- IIC_SDA_I  in  1  SDA line level
- IIC_SCL_O  out  1  SCL drive; constant 1 (released, no clock stretching)
- IIC_SDA_O  out  1  SDA drive; 0 = pull low, 1 = release; reset 1
- IRQ  out  2  IRQ[0]/IRQ[1] interrupt pins, active high; reset 0
- BUSY  out  1  high from address match until STOP/START; reset 0

## Operation
- SCL/SDA pass through 2-FF synchronisers; edges and START (SDA fall, SCL high) / STOP (SDA rise, SCL high) detected on synchronised levels.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state -> ADDR, bit counter cleared (repeated START keeps pointer). STOP from any state -> IDLE.
- ADDR: shift 8 bits MSB-first on SCL rise. Address match -> ADDR_ACK; mismatch -> WAIT_STOP, SDA stays released.
- Write (R/W=0): PTR byte loads pointer, ACKed; subsequent bytes written to register[ptr], ptr++ with wrap to 0 after REG_COUNT-1, each ACKed.
- Read (R/W=1): RD_DATA drives register[ptr] MSB-first; master ACK -> ptr++, next byte; master NACK -> WAIT_STOP.
- Read-only registers: 0x00 (ID), 0x30 (INT_SOURCE); writes ACKed and discarded. Pointer >= REG_COUNT: writes discarded, reads return 0x00.
- Interrupt registers: 0x2E INT_ENABLE, 0x2F INT_MAP (bit i=0 -> IRQ[0], 1 -> IRQ[1]), 0x30 INT_SOURCE.
- Source i (i < IRQ_SOURCES): timer counts only while INT_ENABLE[i]; at zero sets INT_SOURCE[i] and reloads. Disabling clears and reloads the timer.
- INT_SOURCE cleared on completion of the 8th data bit of a read of 0x30; a set event in the same cycle wins.
- IRQ[k] = OR over i of INT_SOURCE[i] & INT_ENABLE[i] & (INT_MAP[i]==k).
- All other registers reset to 0x00.

## Timing
- Pin-to-internal latency: 2 clk synchroniser + 1 clk edge detect.
- Data sampled on synchronised SCL rise; SDA_O updated 1 clk after synchronised SCL fall.
- ACK: SDA_O=0 from the fall after bit 8 until the fall after bit 9, then released (or first read bit driven).
- Register write committed 1 clk after the 8th bit rise; visible to a read in the same transaction.
- STOP/START during a byte abort it; partial byte never written.
- resetn low mid-transfer: immediate IDLE, SDA_O=1, BUSY=0, IRQ=0, timers reloaded.

## Structure
- Package iic_target_pkg: state enum, register addresses (REG_ID, REG_INT_ENABLE, REG_INT_MAP, REG_INT_SOURCE), read-only check function.
- Sub-module iic_line_sync: synchronisers, SCL rise/fall, START/STOP pulses.
- Top contains FSM, bit counter, pointer, register array, interrupt timers.

## Test plan
- Write 0x31 <- 0xAB to address 0x53, read back -> 0xAB, every byte ACKed.
- Address 0x1D -> no ACK on any bit, BUSY stays 0, registers unchanged.
- Burst read 4 bytes from ptr REG_COUNT-2 -> bytes at REG_COUNT-2, REG_COUNT-1, 0x00 (=0xE5), 0x01.
- Write INT_ENABLE=0x03, INT_MAP=0x02, IRQ_SOURCES=2 -> IRQ[0] after INTERRUPT_INTERVAL, IRQ[1] after 2×; read 0x30 -> 0x03 then IRQ=2'b00.
- Write to 0x00 then repeated START read -> 0xE5 returned, write ACKed.
- resetn pulsed mid read byte -> SDA_O=1 immediately, next transaction from START works normally.
